// File: rtl/mc_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : mc_ctrl
//  Purpose  : Multi-cycle processor control unit. A Moore FSM walks each
//             instruction through fetch, decode and its execute/memory/
//             write-back steps. It drives the datapath strobes and selects,
//             flags undefined opcodes, and counts retired instructions.
//  Ports    : clk, rst (async, active-low)
//             opcode[5:0], zero, mem_ready            - inputs
//             PCWrite, PCWriteCond, IorD, MemRead,
//             MemWrite, IRWrite, RegDst, RegWrite,
//             MemtoReg, ALUSrcA, ALUSrcB[1:0],
//             ALUOp[1:0], PCSource[1:0], pc_en        - datapath control
//             illegal                                 - undefined opcode
//             instr_done, retired[CNT_W-1:0]          - retire pulse / count
//             state[3:0]                              - debug state code
//  Revision : 1.0 - initial release
// ============================================================================
module mc_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             RegDst,
    output logic             RegWrite,
    output logic             MemtoReg,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic [1:0]       PCSource,
    output logic             pc_en,
    output logic             illegal,
    output logic             instr_done,
    output logic [CNT_W-1:0] retired,
    output logic [3:0]       state
);

    localparam logic [3:0] c_FETCH  = 4'd0;
    localparam logic [3:0] c_DECODE = 4'd1;
    localparam logic [3:0] c_MEMADR = 4'd2;
    localparam logic [3:0] c_MEMRD  = 4'd3;
    localparam logic [3:0] c_MEMWB  = 4'd4;
    localparam logic [3:0] c_MEMWR  = 4'd5;
    localparam logic [3:0] c_EXEC   = 4'd6;
    localparam logic [3:0] c_RWB    = 4'd7;
    localparam logic [3:0] c_BRANCH = 4'd8;
    localparam logic [3:0] c_JUMP   = 4'd9;
    localparam logic [3:0] c_ADDIEX = 4'd10;
    localparam logic [3:0] c_ADDIWB = 4'd11;

    localparam logic [5:0] c_OP_R    = 6'b000000;
    localparam logic [5:0] c_OP_J    = 6'b000010;
    localparam logic [5:0] c_OP_BEQ  = 6'b000100;
    localparam logic [5:0] c_OP_ADDI = 6'b001000;
    localparam logic [5:0] c_OP_LW   = 6'b100011;
    localparam logic [5:0] c_OP_SW   = 6'b101011;

    localparam logic [CNT_W-1:0] c_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [3:0]       r_state;
    logic             r_instrDone;
    logic [CNT_W-1:0] r_retired;
    logic [3:0]       w_nextState;
    logic             w_retire;

    // Next-state logic. w_retire marks a retiring state that is about to
    // return to FETCH; an illegal opcode goes back to FETCH without it.
    always_comb begin
        w_nextState = c_FETCH;
        w_retire    = 1'b0;
        case (r_state)
            c_FETCH:  w_nextState = mem_ready ? c_DECODE : c_FETCH;
            c_DECODE: begin
                case (opcode)
                    c_OP_LW, c_OP_SW: w_nextState = c_MEMADR;
                    c_OP_R:           w_nextState = c_EXEC;
                    c_OP_BEQ:         w_nextState = c_BRANCH;
                    c_OP_J:           w_nextState = c_JUMP;
                    c_OP_ADDI:        w_nextState = c_ADDIEX;
                    default:          w_nextState = c_FETCH;
                endcase
            end
            c_MEMADR: w_nextState = (opcode == c_OP_LW) ? c_MEMRD : c_MEMWR;
            c_MEMRD:  w_nextState = mem_ready ? c_MEMWB : c_MEMRD;
            c_MEMWB:  w_retire    = 1'b1;
            c_MEMWR: begin
                w_nextState = mem_ready ? c_FETCH : c_MEMWR;
                w_retire    = mem_ready;
            end
            c_EXEC:   w_nextState = c_RWB;
            c_RWB:    w_retire    = 1'b1;
            c_BRANCH: w_retire    = 1'b1;
            c_JUMP:   w_retire    = 1'b1;
            c_ADDIEX: w_nextState = c_ADDIWB;
            c_ADDIWB: w_retire    = 1'b1;
            default:  w_nextState = c_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= c_FETCH;
            r_instrDone <= 1'b0;
            r_retired   <= '0;
        end else begin
            r_state     <= w_nextState;
            r_instrDone <= w_retire;
            if (w_retire) begin
                r_retired <= r_retired + c_ONE;
            end
        end
    end

    // Output decode from the state register. Everything is forced low while
    // reset is held, including the FETCH strobes that would otherwise show.
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        MemtoReg    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUOp       = 2'b00;
        PCSource    = 2'b00;
        illegal     = 1'b0;
        if (rst) begin
            case (r_state)
                c_FETCH: begin
                    MemRead = 1'b1;
                    ALUSrcB = 2'b01;
                    // IR load and PC+4 happen only when the fetch completes
                    IRWrite = mem_ready;
                    PCWrite = mem_ready;
                end
                c_DECODE: begin
                    ALUSrcB = 2'b11;
                    case (opcode)
                        c_OP_LW, c_OP_SW, c_OP_R, c_OP_BEQ,
                        c_OP_J, c_OP_ADDI: illegal = 1'b0;
                        default:           illegal = 1'b1;
                    endcase
                end
                c_MEMADR, c_ADDIEX: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                end
                c_MEMRD: begin
                    MemRead = 1'b1;
                    IorD    = 1'b1;
                end
                c_MEMWB: begin
                    RegWrite = 1'b1;
                    RegDst   = 1'b1;
                    MemtoReg = 1'b1;
                end
                c_MEMWR: begin
                    MemWrite = 1'b1;
                    IorD     = 1'b1;
                end
                c_EXEC: begin
                    ALUSrcA = 1'b1;
                    ALUOp   = 2'b10;
                end
                c_RWB: begin
                    RegWrite = 1'b1;
                end
                c_BRANCH: begin
                    ALUSrcA     = 1'b1;
                    ALUOp       = 2'b01;
                    PCWriteCond = 1'b1;
                    PCSource    = 2'b01;
                end
                c_JUMP: begin
                    PCWrite  = 1'b1;
                    PCSource = 2'b10;
                end
                c_ADDIWB: begin
                    RegWrite = 1'b1;
                    RegDst   = 1'b1;
                end
                default: begin
                    PCWrite = 1'b0;
                end
            endcase
        end
    end

    assign pc_en      = PCWrite | (PCWriteCond & zero);
    assign instr_done = r_instrDone;
    assign retired    = r_retired;
    assign state      = r_state;

endmodule
`default_nettype wire

// File: tb/tb_mc_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mc_ctrl
//  Purpose  : Scoreboard bench for mc_ctrl. Stimulus pushes the expected
//             per-cycle response; a monitor pops and compares on the falling
//             edge.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mc_ctrl;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [5:0]       opcode = 6'd0;
    logic             zero = 1'b0;
    logic             mem_ready = 1'b0;
    logic             PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic             RegDst, RegWrite, MemtoReg, ALUSrcA;
    logic [1:0]       ALUSrcB, ALUOp, PCSource;
    logic             pc_en, illegal, instr_done;
    logic [CNT_W-1:0] retired;
    logic [3:0]       state;

    mc_ctrl #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .RegDst(RegDst), .RegWrite(RegWrite), .MemtoReg(MemtoReg),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .PCSource(PCSource), .pc_en(pc_en), .illegal(illegal),
        .instr_done(instr_done), .retired(retired), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]       st;
        logic [17:0]      ctrl;
        logic             done;
        logic [CNT_W-1:0] ret;
    } vec_t;

    // Control bundle order:
    // PCWrite PCWriteCond IorD MemRead MemWrite IRWrite RegDst RegWrite
    // MemtoReg ALUSrcA ALUSrcB[2] ALUOp[2] PCSource[2] pc_en illegal
    function automatic logic [17:0] mk(
        input logic pcw, input logic pcwc, input logic iord, input logic mrd,
        input logic mwr, input logic irw, input logic rdst, input logic rwr,
        input logic m2r, input logic srca, input logic [1:0] srcb,
        input logic [1:0] aluop, input logic [1:0] pcsrc,
        input logic pcen, input logic ill);
        return {pcw, pcwc, iord, mrd, mwr, irw, rdst, rwr, m2r, srca,
                srcb, aluop, pcsrc, pcen, ill};
    endfunction

    //                                         pcw wc io rd wr ir dst rw m2r sa  sb     op     src    pce ill
    localparam logic [17:0] C_ZERO       = 18'd0;
    localparam logic [17:0] C_FETCH_RDY  = mk(1, 0, 0, 1, 0, 1, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 1, 0);
    localparam logic [17:0] C_FETCH_WAIT = mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 0, 0);
    localparam logic [17:0] C_DECODE     = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 2'b00, 0, 0);
    localparam logic [17:0] C_DECODE_ILL = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 2'b00, 0, 1);
    localparam logic [17:0] C_MEMADR     = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00, 0, 0);
    localparam logic [17:0] C_MEMRD      = mk(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0);
    localparam logic [17:0] C_MEMWB      = mk(0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 2'b00, 2'b00, 2'b00, 0, 0);
    localparam logic [17:0] C_MEMWR      = mk(0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0);
    localparam logic [17:0] C_EXEC       = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b10, 2'b00, 0, 0);
    localparam logic [17:0] C_RWB        = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0);
    localparam logic [17:0] C_BR_T       = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 2'b01, 1, 0);
    localparam logic [17:0] C_BR_F       = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 2'b01, 0, 0);
    localparam logic [17:0] C_JUMP       = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b10, 1, 0);
    localparam logic [17:0] C_ADDIEX     = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00, 0, 0);
    localparam logic [17:0] C_ADDIWB     = mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0);

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BAD  = 6'b111111;

    vec_t             q[$];
    vec_t             mExp;
    vec_t             mAct;
    logic [CNT_W-1:0] expRet = '0;
    int               nVec = 0;
    int               nErr = 0;

    // One cycle of stimulus: drive inputs, queue the expected response for
    // this cycle, then advance to just after the next rising edge.
    task automatic cyc(input logic [5:0] op, input logic z, input logic rdy,
                       input logic [3:0] st, input logic [17:0] c, input logic dn);
        vec_t e;
        opcode    = op;
        zero      = z;
        mem_ready = rdy;
        if (dn) expRet = expRet + {{(CNT_W-1){1'b0}}, 1'b1};
        e.st   = st;
        e.ctrl = c;
        e.done = dn;
        e.ret  = expRet;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic instrJ(input logic dn);
        cyc(OP_J, 0, 1, 4'd0, C_FETCH_RDY, dn);
        cyc(OP_J, 0, 1, 4'd1, C_DECODE,    0);
        cyc(OP_J, 0, 1, 4'd9, C_JUMP,      0);
    endtask

    // Monitor / scoreboard
    initial begin
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                mExp      = q.pop_front();
                mAct.st   = state;
                mAct.ctrl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                             RegDst, RegWrite, MemtoReg, ALUSrcA, ALUSrcB, ALUOp,
                             PCSource, pc_en, illegal};
                mAct.done = instr_done;
                mAct.ret  = retired;
                nVec++;
                if (mAct !== mExp) begin
                    nErr++;
                    $display("FAIL vec%0d: got state=%0d ctrl=%05h done=%b retired=%0d, expected state=%0d ctrl=%05h done=%b retired=%0d",
                             nVec, mAct.st, mAct.ctrl, mAct.done, mAct.ret,
                             mExp.st, mExp.ctrl, mExp.done, mExp.ret);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        // Reset state, including mem_ready=1 which must not leak FETCH strobes
        cyc(OP_LW, 0, 0, 4'd0, C_ZERO, 0);
        cyc(OP_LW, 0, 1, 4'd0, C_ZERO, 0);
        rst = 1'b1;

        // lw: 5 cycles
        cyc(OP_LW, 0, 1, 4'd0, C_FETCH_RDY, 0);
        cyc(OP_LW, 0, 1, 4'd1, C_DECODE,    0);
        cyc(OP_LW, 0, 1, 4'd2, C_MEMADR,    0);
        cyc(OP_LW, 0, 1, 4'd3, C_MEMRD,     0);
        cyc(OP_LW, 0, 1, 4'd4, C_MEMWB,     0);
        // R-type: 4 cycles
        cyc(OP_R, 0, 1, 4'd0, C_FETCH_RDY, 1);
        cyc(OP_R, 0, 1, 4'd1, C_DECODE,    0);
        cyc(OP_R, 0, 1, 4'd6, C_EXEC,      0);
        cyc(OP_R, 0, 1, 4'd7, C_RWB,       0);
        // addi: 4 cycles
        cyc(OP_ADDI, 0, 1, 4'd0,  C_FETCH_RDY, 1);
        cyc(OP_ADDI, 0, 1, 4'd1,  C_DECODE,    0);
        cyc(OP_ADDI, 0, 1, 4'd10, C_ADDIEX,    0);
        cyc(OP_ADDI, 0, 1, 4'd11, C_ADDIWB,    0);
        // beq taken (zero=1) then not taken (zero=0)
        cyc(OP_BEQ, 1, 1, 4'd0, C_FETCH_RDY, 1);
        cyc(OP_BEQ, 1, 1, 4'd1, C_DECODE,    0);
        cyc(OP_BEQ, 1, 1, 4'd8, C_BR_T,      0);
        cyc(OP_BEQ, 0, 1, 4'd0, C_FETCH_RDY, 1);
        cyc(OP_BEQ, 0, 1, 4'd1, C_DECODE,    0);
        cyc(OP_BEQ, 0, 1, 4'd8, C_BR_F,      0);
        // sw with a fetch wait and three memory wait cycles
        cyc(OP_SW, 0, 0, 4'd0, C_FETCH_WAIT, 1);
        cyc(OP_SW, 0, 1, 4'd0, C_FETCH_RDY,  0);
        cyc(OP_SW, 0, 1, 4'd1, C_DECODE,     0);
        cyc(OP_SW, 0, 1, 4'd2, C_MEMADR,     0);
        cyc(OP_SW, 0, 0, 4'd5, C_MEMWR,      0);
        cyc(OP_SW, 0, 0, 4'd5, C_MEMWR,      0);
        cyc(OP_SW, 0, 0, 4'd5, C_MEMWR,      0);
        cyc(OP_SW, 0, 1, 4'd5, C_MEMWR,      0);
        // illegal opcode: flagged in DECODE, no retire
        cyc(OP_BAD, 0, 1, 4'd0, C_FETCH_RDY,  1);
        cyc(OP_BAD, 0, 1, 4'd1, C_DECODE_ILL, 0);
        instrJ(0);
        // run jumps until the 4-bit retire counter wraps past 15
        for (int k = 0; k < 10; k++) begin
            instrJ(1);
        end
        // lw abandoned by reset while waiting in MEMRD
        cyc(OP_LW, 0, 1, 4'd0, C_FETCH_RDY, 1);
        cyc(OP_LW, 0, 1, 4'd1, C_DECODE,    0);
        cyc(OP_LW, 0, 1, 4'd2, C_MEMADR,    0);
        cyc(OP_LW, 0, 0, 4'd3, C_MEMRD,     0);
        rst    = 1'b0;
        expRet = '0;
        cyc(OP_LW, 0, 0, 4'd0, C_ZERO, 0);
        cyc(OP_LW, 0, 1, 4'd0, C_ZERO, 0);
        rst = 1'b1;
        instrJ(0);
        cyc(OP_J, 0, 0, 4'd0, C_FETCH_WAIT, 1);

        for (int i = 0; i < 10; i++) begin
            if (q.size() == 0) break;
            @(negedge clk);
            #1;
        end
        if (q.size() != 0) begin
            nErr++;
            $display("FAIL drain: got %0d unchecked vectors, expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mc_ctrl.md
MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 Parameter CNT_W, default 32: width of the retired-instruction counter.
REQ-002 clk  in  1  clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-low.
REQ-004 opcode  in  6  instruction[31:26] from instruction register.
REQ-005 zero  in  1  ALU zero flag.
REQ-006 mem_ready  in  1  memory handshake; current read/write completes this cycle.
REQ-007 PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite  out  1 each  datapath strobes.
REQ-008 RegDst  out  1  register-file destination select: 0=rd, 1=rt.
REQ-009 RegWrite  out  1  register-file write enable.
REQ-010 MemtoReg  out  1  write-data select: 0=ALU result, 1=memory data.
REQ-011 ALUSrcA  out  1; ALUSrcB  out  2; ALUOp  out  2; PCSource  out  2  datapath selects.
REQ-012 pc_en  out  1  = PCWrite | (PCWriteCond & zero).
REQ-013 illegal  out  1  undefined-opcode flag.
REQ-014 instr_done  out  1  one-cycle retire pulse.
REQ-015 retired  out  CNT_W  count of retired instructions.
REQ-016 state  out  4  current state code, for debug.

Function
REQ-017 Moore FSM; outputs decode from the state register except the FETCH handshake strobes (REQ-019); any output not listed for a state is 0.
REQ-018 State codes: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RWB=7, BRANCH=8, JUMP=9, ADDIEX=10, ADDIWB=11; codes 12-15 go to FETCH on the next edge.
REQ-019 FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00; IRWrite=PCWrite=mem_ready; stays in FETCH while mem_ready=0, goes to DECODE when 1.
REQ-020 DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00; next state by opcode: 100011/101011 -> MEMADR, 000000 -> EXEC, 000100 -> BRANCH, 000010 -> JUMP, 001000 -> ADDIEX, any other -> FETCH with illegal=1 for that DECODE cycle.
REQ-021 MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00; goes to MEMRD if opcode=100011, otherwise MEMWR.
REQ-022 MEMRD: MemRead=1, IorD=1; waits for mem_ready=1, then goes to MEMWB.
REQ-023 MEMWB: RegWrite=1, RegDst=1, MemtoReg=1; goes to FETCH.
REQ-024 MEMWR: MemWrite=1, IorD=1; waits for mem_ready=1, then goes to FETCH.
REQ-025 EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10; goes to RWB. RWB: RegWrite=1, RegDst=0, MemtoReg=0; goes to FETCH.
REQ-026 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01; goes to FETCH.
REQ-027 JUMP: PCWrite=1, PCSource=10; goes to FETCH.
REQ-028 ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00; goes to ADDIWB. ADDIWB: RegWrite=1, RegDst=1, MemtoReg=0; goes to FETCH.
REQ-029 Retiring states are MEMWB, MEMWR (with mem_ready=1), RWB, BRANCH, JUMP and ADDIWB.
REQ-030 instr_done is registered: 1 for exactly the cycle after a retiring state transitions to FETCH; it is never set for an illegal opcode.
REQ-031 retired increments by 1 on each edge that sets instr_done and wraps from 2^CNT_W-1 to 0.
REQ-032 RegWrite and MemWrite are never 1 in the same cycle; at most one write strobe per instruction.
REQ-033 Cycle counts with mem_ready tied to 1: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3; each mem_ready=0 cycle in FETCH/MEMRD/MEMWR adds 1.

Reset
REQ-034 rst=0 forces state=FETCH, instr_done=0 and retired=0 asynchronously.
REQ-035 While rst=0: PCWrite, PCWriteCond, IRWrite, MemRead, MemWrite, RegWrite, pc_en, illegal are 0; all selects are 0.
REQ-036 Reset asserted mid-instruction abandons the instruction with no retire pulse and no count; first edge after release evaluates FETCH.

Verification
REQ-037 lw, mem_ready=1 -> states 0,1,2,3,4; RegWrite=1, RegDst=1, MemtoReg=1 only in cycle 5; instr_done next cycle; retired=1.
REQ-038 R-type then addi -> RWB has RegDst=0/MemtoReg=0, ADDIWB has RegDst=1/MemtoReg=0; retired=2 after 8 cycles.
REQ-039 beq with zero=1 in BRANCH -> pc_en=1, PCSource=01; with zero=0 -> pc_en=0; both retire.
REQ-040 sw with mem_ready low for 3 cycles in MEMWR -> MemWrite held 4 cycles, RegWrite never 1, retire after mem_ready=1.
REQ-041 opcode 111111 -> illegal=1 in DECODE, return to FETCH, instr_done=0, retired unchanged.
REQ-042 rst pulled low in MEMRD -> outputs 0 immediately, state=0, retired=0; after release a new FETCH completes normally.
